// File: rtl/wb_arbdec.sv
// Wishbone shared-bus interconnect: round-robin arbiter, address decoder and bus-error generator.
// Define WB_ARBDEC_TIMEOUT_EN to add the stalled-cycle timeout counter.
module wb_arbdec #(
  parameter int unsigned NUM_MASTERS = 7,
  parameter int unsigned NUM_SLAVES  = 6,
  parameter int unsigned DEC_W       = 3,
  parameter logic [NUM_SLAVES*DEC_W-1:0] SLAVE_ADDRS = {3'h5, 3'h4, 3'h3, 3'h2, 3'h1, 3'h0},
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [32*NUM_MASTERS-1:0] m_dat_i,
  output logic [32*NUM_MASTERS-1:0] m_dat_o,
  input  logic [32*NUM_MASTERS-1:0] m_adr_i,
  input  logic [3*NUM_MASTERS-1:0]  m_cti_i,
  input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [31:0]               s_dat_o,
  output logic [31:0]               s_adr_o,
  output logic [2:0]                s_cti_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_we_o,
  output logic [NUM_SLAVES-1:0]     s_cyc_o,
  output logic [NUM_SLAVES-1:0]     s_stb_o,
  input  logic [32*NUM_SLAVES-1:0]  s_dat_i,
  input  logic [NUM_SLAVES-1:0]     s_ack_i
);

  localparam int unsigned MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [0:0] {StIdle, StOwned} state_e;

  state_e                 st_q, st_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [MW-1:0]          own_q, own_d, last_q, last_d;
  logic                   err_q, err_d;

  logic                   owned, own_cyc, own_stb;
  logic                   found;
  logic [MW-1:0]          pick, cand;
  logic [NUM_SLAVES-1:0]  hit;
  logic                   hit_any;
  logic [SW-1:0]          hit_idx;
  logic                   sel_ack, err_out, to_hit;
  logic [31:0]            sel_dat;

  assign owned   = (st_q == StOwned);
  assign own_cyc = owned & m_cyc_i[own_q];
  assign own_stb = owned & m_stb_i[own_q];

  // Round-robin pick: first requester scanning upward from last+1.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    cand  = '0;
    for (int unsigned off = 1; off <= NUM_MASTERS; off++) begin
      cand = MW'((32'(last_q) + off) % NUM_MASTERS);
      if (!found && m_cyc_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    st_d   = st_q;
    gnt_d  = gnt_q;
    own_d  = own_q;
    last_d = last_q;
    unique case (st_q)
      StIdle: begin
        if (found) begin
          st_d        = StOwned;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          own_d       = pick;
          last_d      = pick;
        end
      end
      StOwned: begin
        if (!own_cyc) begin
          st_d  = StIdle;
          gnt_d = '0;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      st_q   <= StIdle;
      gnt_q  <= '0;
      own_q  <= '0;
      last_q <= MW'(NUM_MASTERS - 1);
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      gnt_q  <= gnt_d;
      own_q  <= own_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_cti_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    if (owned) begin
      s_adr_o = m_adr_i[32*own_q +: 32];
      s_dat_o = m_dat_i[32*own_q +: 32];
      s_cti_o = m_cti_i[3*own_q +: 3];
      s_sel_o = m_sel_i[4*own_q +: 4];
      s_we_o  = m_we_i[own_q];
    end
  end

  // Priority decode: the lowest matching slave wins on overlapping fields.
  always_comb begin
    hit     = '0;
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (owned && !hit_any && (s_adr_o[31 -: DEC_W] == SLAVE_ADDRS[k*DEC_W +: DEC_W])) begin
        hit[k]  = 1'b1;
        hit_any = 1'b1;
        hit_idx = SW'(k);
      end
    end
  end

  assign sel_ack = hit_any & s_ack_i[hit_idx];
  assign sel_dat = hit_any ? s_dat_i[32*hit_idx +: 32] : 32'h0;

  // Unmapped access: err on the cycle after stb is seen, alternating while stb is held.
  assign err_d = own_cyc & own_stb & ~hit_any & ~err_q;

`ifdef WB_ARBDEC_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign to_hit  = own_cyc & own_stb & hit_any & (cnt_q == 16'(TIMEOUT));
  assign err_out = err_q | (to_hit & ~sel_ack);

  always_comb begin
    cnt_d = '0;
    if (own_cyc && own_stb && !sel_ack && !err_out && !to_hit) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Without the counter a timeout can never fire; TIMEOUT is always non-zero.
  assign to_hit  = (TIMEOUT == 0);
  assign err_out = err_q;
`endif

  assign s_cyc_o = hit & {NUM_SLAVES{own_cyc}};
  assign s_stb_o = hit & {NUM_SLAVES{own_stb & ~to_hit}};
  assign m_dat_o = {NUM_MASTERS{sel_dat}};
  assign m_ack_o = gnt_q & {NUM_MASTERS{sel_ack}};
  assign m_err_o = gnt_q & {NUM_MASTERS{err_out}};

endmodule
